// File: rtl/mul_opd_unpack_pkg.sv
// Shared types and constants for the FP multiplier operand front end.
// Every struct here is sized from the default field widths.
package mul_pkg;

    localparam int EXPO_W_D = 8;
    localparam int MANT_W_D = 23;

    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    typedef struct packed {
        logic                sign;
        logic [EXPO_W_D-1:0] expo;
        logic [MANT_W_D-1:0] mant;
    } fp_opd_t;

    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic nan;
        logic snan;
    } fp_class_t;

    typedef struct packed {
        logic                sign_1;
        logic [EXPO_W_D-1:0] expo_a;
        logic [EXPO_W_D-1:0] expo_b;
        logic [MANT_W_D:0]   mant_a;
        logic [MANT_W_D:0]   mant_b;
        logic [EXPO_W_D+1:0] expo_sum;
        logic                is_zero;
        logic                is_inf_nan;
        logic                sign_nan;
        logic [MANT_W_D-1:0] nan_mant;
        logic                invalid;
        logic [1:0]          rnd;
    } unpack_res_t;

endpackage

// File: rtl/mul_opd_unpack_fp_classify.sv
// Per-operand unpack: effective exponent, significand with hidden bit,
// and the IEEE class bits.
module fp_classify
    import mul_pkg::*;
(
    input  fp_opd_t             i_opd,
    output logic                o_sign,
    output logic [EXPO_W_D-1:0] o_expo,
    output logic [MANT_W_D:0]   o_mant,
    output fp_class_t           o_cls
);

    logic w_e_zero;
    logic w_e_ones;
    logic w_m_zero;

    assign w_e_zero = (i_opd.expo == '0);
    assign w_e_ones = &i_opd.expo;
    assign w_m_zero = (i_opd.mant == '0);

    // Subnormals and zero share exponent 1 so the exponent sum needs no special case.
    assign o_sign = i_opd.sign;
    assign o_expo = w_e_zero ? EXPO_W_D'(1) : i_opd.expo;
    assign o_mant = {~w_e_zero, i_opd.mant};

    assign o_cls.zero = w_e_zero & w_m_zero;
    assign o_cls.sub  = w_e_zero & ~w_m_zero;
    assign o_cls.inf  = w_e_ones & w_m_zero;
    assign o_cls.nan  = w_e_ones & ~w_m_zero;
    assign o_cls.snan = w_e_ones & ~w_m_zero & ~i_opd.mant[MANT_W_D-1];

endmodule

// File: rtl/mul_opd_unpack.sv
// Operand unpack stage of the FP multiplier: classify, resolve specials,
// sum exponents, then register behind a one-entry skid buffer.
module mul_opd_unpack
    import mul_pkg::*;
#(
    parameter int EXPO_W = EXPO_W_D,
    parameter int MANT_W = MANT_W_D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXPO_W+MANT_W:0]   opa,
    input  logic [EXPO_W+MANT_W:0]   opb,
    input  logic [1:0]               rnd_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sign_1,
    output logic [EXPO_W-1:0]        expo_a,
    output logic [EXPO_W-1:0]        expo_b,
    output logic [MANT_W:0]          mant_a,
    output logic [MANT_W:0]          mant_b,
    output logic signed [EXPO_W+1:0] expo_sum,
    output logic                     is_zero,
    output logic                     is_inf_nan,
    output logic                     sign_nan,
    output logic [MANT_W-1:0]        nan_mant,
    output logic                     invalid,
    output logic [1:0]               rnd_o
);

    localparam logic [EXPO_W+1:0] BIAS_W = (EXPO_W + 2)'(bias(EXPO_W));

    fp_opd_t     w_opa, w_opb;
    fp_class_t   w_ca, w_cb;
    logic        w_sa, w_sb;
    logic [EXPO_W-1:0] w_ea, w_eb;
    logic [MANT_W:0]   w_ma, w_mb;
    logic        w_a_spec, w_b_spec, w_inf_zero;
    unpack_res_t w_res;

    unpack_res_t r_out, r_skid;
    logic        r_out_vld, r_skid_vld;
    logic        w_acc, w_fire;

    assign w_opa = opa;
    assign w_opb = opb;

    fp_classify u_cls_a (.i_opd(w_opa), .o_sign(w_sa), .o_expo(w_ea), .o_mant(w_ma), .o_cls(w_ca));
    fp_classify u_cls_b (.i_opd(w_opb), .o_sign(w_sb), .o_expo(w_eb), .o_mant(w_mb), .o_cls(w_cb));

    assign w_a_spec   = w_ca.inf | w_ca.nan;
    assign w_b_spec   = w_cb.inf | w_cb.nan;
    assign w_inf_zero = (w_ca.inf & w_cb.zero) | (w_cb.inf & w_ca.zero);

    always_comb begin
        w_res          = '0;
        w_res.sign_1   = w_sa ^ w_sb;
        w_res.expo_a   = w_ea;
        w_res.expo_b   = w_eb;
        w_res.mant_a   = w_ma;
        w_res.mant_b   = w_mb;
        // Two zero-extension bits keep the full range, including negatives, without wrap.
        w_res.expo_sum = {2'b00, w_ea} + {2'b00, w_eb} - BIAS_W;
        w_res.is_zero  = (w_ca.zero | w_cb.zero) & ~w_a_spec & ~w_b_spec;
        w_res.invalid  = w_ca.snan | w_cb.snan | w_inf_zero;
        w_res.rnd      = rnd_i;
        if (w_ca.nan) begin
            w_res.is_inf_nan = 1'b1;
            w_res.nan_mant   = {1'b1, w_opa.mant[MANT_W-2:0]};
            w_res.sign_nan   = w_sa;
        end else if (w_cb.nan) begin
            w_res.is_inf_nan = 1'b1;
            w_res.nan_mant   = {1'b1, w_opb.mant[MANT_W-2:0]};
            w_res.sign_nan   = w_sb;
        end else if (w_inf_zero) begin
            w_res.is_inf_nan = 1'b1;
            w_res.nan_mant   = {1'b1, {(MANT_W-1){1'b0}}};
        end else if (w_a_spec | w_b_spec) begin
            w_res.is_inf_nan = 1'b1;
            w_res.sign_nan   = w_sa ^ w_sb;
        end
    end

    assign in_ready = ~r_skid_vld;
    assign w_acc    = in_valid & ~r_skid_vld;
    assign w_fire   = r_out_vld & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_out      <= '0;
            r_skid     <= '0;
        end else if (w_fire || !r_out_vld) begin
            // Output slot frees up: skid drains first to keep order.
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= w_acc;
                if (w_acc) r_out <= w_res;
            end
        end else if (w_acc) begin
            r_skid     <= w_res;
            r_skid_vld <= 1'b1;
        end
    end

    a_skid_needs_out: assert property (@(posedge clk) disable iff (!rst_n) !(r_skid_vld && !r_out_vld));

    assign out_valid  = r_out_vld;
    assign sign_1     = r_out.sign_1;
    assign expo_a     = r_out.expo_a;
    assign expo_b     = r_out.expo_b;
    assign mant_a     = r_out.mant_a;
    assign mant_b     = r_out.mant_b;
    assign expo_sum   = r_out.expo_sum;
    assign is_zero    = r_out.is_zero;
    assign is_inf_nan = r_out.is_inf_nan;
    assign sign_nan   = r_out.sign_nan;
    assign nan_mant   = r_out.nan_mant;
    assign invalid    = r_out.invalid;
    assign rnd_o      = r_out.rnd;

endmodule
